// File: rtl/ysyx_23060208_lsu_pkg.sv
// rtl/ysyx_23060208_lsu_pkg.sv - shared types and constants for the load/store unit
// Purpose: FSM state enum, access size encodings, AXI response codes and the
//          response-error decode used by the LSU top level.
// Ports:   none (package).
package ysyx_23060208_lsu_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_AR  = 3'd1,
      S_RD_R   = 3'd2,
      S_WR_REQ = 3'd3,
      S_WR_B   = 3'd4,
      S_RESP   = 3'd5
   } lsu_state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   // Both error codes have bit 1 set; decoding by value keeps the intent explicit.
   function automatic logic resp_is_err(input logic [1:0] i_resp);
      return (i_resp == SLVERR) || (i_resp == DECERR);
   endfunction

endpackage

// File: rtl/ysyx_23060208_lsu_align.sv
// rtl/ysyx_23060208_lsu_align.sv - combinational lane alignment for the LSU
// Purpose: store lane shift and byte-strobe generation, load lane shift,
//          truncation and sign/zero extension, and alignment legality check.
// Ports:   i_offset   byte offset of the access within the bus word
//          i_size     log2 of access bytes
//          i_unsigned zero-extend loads when 1
//          i_wdata    right-aligned store data
//          i_rdata    raw bus read data
//          o_wdata    store data shifted onto its byte lanes
//          o_wstrb    per-byte write strobes
//          o_rdata    extracted and extended load data
//          o_illegal  access misaligned or wider than the bus
module ysyx_23060208_lsu_align #(
   parameter int  DATA_WIDTH = 32,
   localparam int NBYTES     = DATA_WIDTH / 8,
   localparam int OFFW       = $clog2(NBYTES)
) (
   input  logic [OFFW-1:0]       i_offset,
   input  logic [1:0]            i_size,
   input  logic                  i_unsigned,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [DATA_WIDTH-1:0] i_rdata,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic [NBYTES-1:0]     o_wstrb,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_illegal
);

   int                  w_nbytes;
   logic [NBYTES-1:0]   w_bmask;
   logic [DATA_WIDTH-1:0] w_shift;
   logic                w_sign;

   always_comb begin
      w_nbytes = 1 << i_size;

      w_bmask = '0;
      for (int i = 0; i < NBYTES; i++) begin
         w_bmask[i] = (i < w_nbytes);
      end
      o_wstrb = w_bmask << i_offset;
      o_wdata = i_wdata << {i_offset, 3'b000};

      o_illegal = (w_nbytes > NBYTES) || ((int'(i_offset) & (w_nbytes - 1)) != 0);

      // Bring the addressed bytes down to lane 0, then fill above the access
      // width with either zeros or the access's own top bit.
      w_shift = i_rdata >> {i_offset, 3'b000};
      w_sign  = 1'b0;
      for (int b = 0; b < DATA_WIDTH; b++) begin
         if (b == 8 * w_nbytes - 1) begin
            w_sign = w_shift[b];
         end
      end
      for (int b = 0; b < DATA_WIDTH; b++) begin
         o_rdata[b] = (b < 8 * w_nbytes) ? w_shift[b] : (w_sign & ~i_unsigned);
      end
   end

endmodule

// File: rtl/ysyx_23060208_lsu.sv
// rtl/ysyx_23060208_lsu.sv - load/store unit between the EXU and the AXI4-Lite data bus
// Purpose: accepts one EXU memory request at a time, runs the matching AXI
//          read or write with registered valids/readies, returns extended
//          load data or store completion with an error flag.
// Ports:   clk, rst                      clock, synchronous active-high reset
//          req_*                         EXU request handshake and fields
//          resp_*                        EXU response handshake, data, error
//          aw*, w*, b*                   AXI4-Lite write channels
//          ar*, r*                       AXI4-Lite read channels
module ysyx_23060208_lsu
   import ysyx_23060208_lsu_pkg::*;
#(
   parameter int  DATA_WIDTH = 32,
   parameter int  ADDR_WIDTH = 32,
   localparam int NBYTES     = DATA_WIDTH / 8,
   localparam int OFFW       = $clog2(NBYTES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [NBYTES-1:0]     wstrb,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic                  rready
);

   lsu_state_t            r_state, w_state_nxt;

   logic [OFFW-1:0]       r_offset;
   logic [1:0]            r_size;
   logic                  r_unsigned;

   logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [NBYTES-1:0]     r_wstrb;
   logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
   logic [DATA_WIDTH-1:0] r_resp_rdata;
   logic                  r_resp_err;

   logic                  w_idle;
   logic [OFFW-1:0]       w_offset;
   logic [1:0]            w_size;
   logic [DATA_WIDTH-1:0] w_st_wdata, w_ld_rdata;
   logic [NBYTES-1:0]     w_st_wstrb;
   logic                  w_illegal;
   logic                  w_aw_done, w_w_done;

   assign w_idle = (r_state == S_IDLE);

   // In IDLE the aligner sees the live request (store lanes and legality are
   // registered at acceptance); afterwards it sees the latched request so the
   // load path can extend rdata when it arrives.
   assign w_offset = w_idle ? req_addr[OFFW-1:0] : r_offset;
   assign w_size   = w_idle ? req_size           : r_size;

   ysyx_23060208_lsu_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .i_offset   (w_offset),
      .i_size     (w_size),
      .i_unsigned (r_unsigned),
      .i_wdata    (req_wdata),
      .i_rdata    (rdata),
      .o_wdata    (w_st_wdata),
      .o_wstrb    (w_st_wstrb),
      .o_rdata    (w_ld_rdata),
      .o_illegal  (w_illegal)
   );

   // A write channel is finished once its valid has dropped or it handshakes now.
   assign w_aw_done = !r_awvalid || awready;
   assign w_w_done  = !r_wvalid  || wready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_illegal)    w_state_nxt = S_RESP;
               else if (req_wen) w_state_nxt = S_WR_REQ;
               else              w_state_nxt = S_RD_AR;
            end
         end
         S_RD_AR:  if (arready) w_state_nxt = S_RD_R;
         S_RD_R:   if (rvalid) w_state_nxt = S_RESP;
         S_WR_REQ: if (w_aw_done && w_w_done) w_state_nxt = S_WR_B;
         S_WR_B:   if (bvalid) w_state_nxt = S_RESP;
         S_RESP:   if (resp_ready) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_offset     <= '0;
         r_size       <= SZ_B;
         r_unsigned   <= 1'b0;
         r_awaddr     <= '0;
         r_araddr     <= '0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_awvalid    <= 1'b0;
         r_wvalid     <= 1'b0;
         r_bready     <= 1'b0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_offset   <= req_addr[OFFW-1:0];
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  if (w_illegal) begin
                     r_resp_rdata <= '0;
                     r_resp_err   <= 1'b1;
                  end else if (req_wen) begin
                     r_awaddr  <= req_addr;
                     r_wdata   <= w_st_wdata;
                     r_wstrb   <= w_st_wstrb;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                  end else begin
                     r_araddr  <= req_addr;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            S_RD_AR: begin
               if (arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
               end
            end
            S_RD_R: begin
               if (rvalid) begin
                  r_rready     <= 1'b0;
                  r_resp_rdata <= w_ld_rdata;
                  r_resp_err   <= resp_is_err(rresp);
               end
            end
            S_WR_REQ: begin
               if (awready) r_awvalid <= 1'b0;
               if (wready)  r_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) r_bready <= 1'b1;
            end
            S_WR_B: begin
               if (bvalid) begin
                  r_bready     <= 1'b0;
                  r_resp_rdata <= '0;
                  r_resp_err   <= resp_is_err(bresp);
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = w_idle;
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign awaddr     = r_awaddr;
   assign awvalid    = r_awvalid;
   assign wdata      = r_wdata;
   assign wstrb      = r_wstrb;
   assign wvalid     = r_wvalid;
   assign bready     = r_bready;
   assign araddr     = r_araddr;
   assign arvalid    = r_arvalid;
   assign rready     = r_rready;

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// tb/tb_ysyx_23060208_lsu.sv - self-checking bench for ysyx_23060208_lsu (32- and 64-bit instances)
module tb_ysyx_23060208_lsu;

   localparam int NB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int step   = 0;

   // 32-bit instance
   logic        rst;
   logic        req_valid, req_ready, req_wen, req_unsigned;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   ysyx_23060208_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   // 64-bit instance
   logic        d_rst;
   logic        d_req_valid, d_req_ready, d_req_wen, d_req_unsigned;
   logic [31:0] d_req_addr, d_awaddr, d_araddr;
   logic [63:0] d_req_wdata, d_resp_rdata, d_wdata, d_rdata;
   logic [1:0]  d_req_size, d_bresp, d_rresp;
   logic        d_resp_valid, d_resp_ready, d_resp_err;
   logic        d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready;
   logic        d_arvalid, d_arready, d_rvalid, d_rready;
   logic [7:0]  d_wstrb;

   ysyx_23060208_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
      .clk(clk), .rst(d_rst),
      .req_valid(d_req_valid), .req_ready(d_req_ready), .req_wen(d_req_wen),
      .req_addr(d_req_addr), .req_size(d_req_size), .req_unsigned(d_req_unsigned),
      .req_wdata(d_req_wdata),
      .resp_valid(d_resp_valid), .resp_ready(d_resp_ready),
      .resp_rdata(d_resp_rdata), .resp_err(d_resp_err),
      .awaddr(d_awaddr), .awvalid(d_awvalid), .awready(d_awready),
      .wdata(d_wdata), .wstrb(d_wstrb), .wvalid(d_wvalid), .wready(d_wready),
      .bresp(d_bresp), .bvalid(d_bvalid), .bready(d_bready),
      .araddr(d_araddr), .arvalid(d_arvalid), .arready(d_arready),
      .rdata(d_rdata), .rresp(d_rresp), .rvalid(d_rvalid), .rready(d_rready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s (step %0d): observed=%h expected=%h", tag, step, obs, exp);
      end
   endtask

   // Reference load: pick the addressed bytes, then extend by arithmetic shifts.
   function automatic logic [63:0] m_load(input logic [63:0] data, input int off,
                                          input int bytes, input bit uns);
      logic [63:0] v;
      int sh;
      sh = 64 - 8 * bytes;
      v  = (data >> (8 * off)) << sh;
      if (uns) return v >> sh;
      return $signed(v) >>> sh;
   endfunction

   task automatic access(input bit wen, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wd, input logic [31:0] rd,
                         input logic [1:0] rsp, input int d_a, input int d_w,
                         input int d_d, input int d_resp, input bit chk_lat);
      int bytes, off, cyc, ca, cw, cd, cr, nar, naw, nw, nd;
      bit ill, done, seen, bad_ready, any_valid;
      logic [31:0] exp_rd, exp_wd;
      logic [3:0]  exp_strb;
      logic        exp_err;
      step++;
      bytes  = 1 << size;
      off    = int'(addr % NB);
      ill    = (bytes > NB) || ((addr % bytes) != 0);
      exp_rd = (ill || wen) ? 32'h0 : 32'(m_load({32'h0, rd}, off, bytes, uns));
      exp_err = ill ? 1'b1 : rsp[1];
      exp_wd = wd << (8 * off);
      exp_strb = '0;
      for (int k = 0; k < bytes; k++) if (off + k < NB) exp_strb[off + k] = 1'b1;
      cyc = 0; ca = 0; cw = 0; cd = 0; cr = 0; nar = 0; naw = 0; nw = 0; nd = 0;
      done = 0; seen = 0; bad_ready = 0; any_valid = 0;

      chk("req_ready_idle", {63'h0, req_ready}, 64'h1);
      req_valid = 1; req_wen = wen; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wd;
      @(negedge clk);
      cyc = 1;
      req_valid = 0; req_wen = $urandom; req_addr = $urandom; req_size = $urandom;
      req_unsigned = $urandom; req_wdata = $urandom;

      while (!done && cyc < 200) begin
         arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; resp_ready = 0;
         rdata = $urandom; rresp = rsp; bresp = rsp;
         if (arvalid || awvalid || wvalid) any_valid = 1;
         if (arvalid) begin
            arready = (ca >= d_a); ca++;
            if (arready) begin nar++; chk("araddr", {32'h0, araddr}, {32'h0, addr}); end
         end
         if (rready) begin
            rvalid = (cd >= d_d); cd++;
            if (rvalid) begin nd++; rdata = rd; end
         end
         if (awvalid) begin
            awready = (ca >= d_a); ca++;
            if (awready) begin naw++; chk("awaddr", {32'h0, awaddr}, {32'h0, addr}); end
         end
         if (wvalid) begin
            wready = (cw >= d_w); cw++;
            if (wready) begin
               nw++;
               chk("wdata", {32'h0, wdata}, {32'h0, exp_wd});
               chk("wstrb", {60'h0, wstrb}, {60'h0, exp_strb});
            end
         end
         if (bready) begin
            bvalid = (cd >= d_d); cd++;
            if (bvalid) nd++;
         end
         if (resp_valid) begin
            if (req_ready) bad_ready = 1;
            if (!seen) begin
               seen = 1;
               if (chk_lat) chk("resp_latency", 64'(cyc), ill ? 64'd1 : 64'd3);
               chk("resp_rdata_first", {32'h0, resp_rdata}, {32'h0, exp_rd});
               chk("resp_err_first", {63'h0, resp_err}, {63'h0, exp_err});
            end
            resp_ready = (cr >= d_resp); cr++;
            if (resp_ready) begin
               done = 1;
               chk("resp_rdata_accept", {32'h0, resp_rdata}, {32'h0, exp_rd});
               chk("resp_err_accept", {63'h0, resp_err}, {63'h0, exp_err});
            end
         end
         @(negedge clk);
         cyc++;
      end
      arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; resp_ready = 0;
      chk("completed", {63'h0, done}, 64'h1);
      chk("ar_count", 64'(nar), (!ill && !wen) ? 64'd1 : 64'd0);
      chk("aw_w_count", {32'(naw), 32'(nw)}, (!ill && wen) ? {32'd1, 32'd1} : 64'd0);
      chk("data_resp_count", 64'(nd), ill ? 64'd0 : 64'd1);
      if (ill) chk("illegal_no_bus", {63'h0, any_valid}, 64'h0);
      chk("req_ready_during_resp", {63'h0, bad_ready}, 64'h0);
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      rst = 1; req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_unsigned = 0;
      req_wdata = 0; resp_ready = 0; awready = 0; wready = 0; bresp = 0; bvalid = 0;
      arready = 0; rdata = 0; rresp = 0; rvalid = 0;
      d_rst = 1; d_req_valid = 0; d_req_wen = 0; d_req_addr = 0; d_req_size = 0;
      d_req_unsigned = 0; d_req_wdata = 0; d_resp_ready = 0; d_awready = 0; d_wready = 0;
      d_bresp = 0; d_bvalid = 0; d_arready = 0; d_rdata = 0; d_rresp = 0; d_rvalid = 0;

      @(negedge clk);
      @(negedge clk);
      chk("reset_req_ready", {63'h0, req_ready}, 64'h1);
      chk("reset_valids_readies",
          {57'h0, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err}, 64'h0);
      chk("reset_addrs", {awaddr, araddr}, 64'h0);
      chk("reset_data", {wdata, resp_rdata}, 64'h0);
      chk("reset_wstrb", {60'h0, wstrb}, 64'h0);
      rst = 0;
      @(negedge clk);

      // wen addr size uns wdata rdata rsp d_a d_w d_d d_resp lat
      access(0, 32'h8000_0003, 2'd0, 0, 32'h0, 32'h80FF_FFFF, 2'b00, 0, 0, 0, 0, 1);
      access(1, 32'h8000_0002, 2'd1, 0, 32'h0000_1234, 32'h0, 2'b00, 0, 2, 1, 0, 0);
      access(1, 32'h8000_0000, 2'd2, 0, 32'hCAFE_BABE, 32'h0, 2'b00, 3, 0, 0, 0, 0);
      access(0, 32'h8000_0001, 2'd2, 0, 32'h0, 32'h1234_5678, 2'b00, 0, 0, 0, 0, 1);
      access(1, 32'h8000_0003, 2'd1, 0, 32'hFFFF, 32'h0, 2'b00, 0, 0, 0, 0, 1);
      access(0, 32'h8000_0000, 2'd3, 0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 0, 1);
      access(0, 32'h8000_0004, 2'd2, 0, 32'h0, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, 1);
      access(1, 32'h8000_0008, 2'd2, 0, 32'h1111_2222, 32'h0, 2'b11, 0, 0, 0, 0, 1);
      access(0, 32'h8000_0002, 2'd1, 1, 32'h0, 32'h9ABC_0000, 2'b00, 1, 0, 2, 5, 0);
      access(0, 32'h8000_0001, 2'd0, 1, 32'h0, 32'h0000_F100, 2'b01, 0, 0, 0, 0, 1);

      for (int i = 0; i < 80; i++) begin
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         access(1'($urandom), a, sz, 1'($urandom), $urandom, $urandom, 2'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), 0);
      end

      // 64-bit bus: full doubleword, a signed byte from an upper lane, then reset in RD_R
      step++;
      d_rst = 0;
      @(negedge clk);
      d_req_valid = 1; d_req_addr = 32'h8; d_req_size = 2'd3; d_req_unsigned = 0;
      @(negedge clk);
      d_req_valid = 0;
      chk("d_araddr", {32'h0, d_araddr}, 64'h8);
      chk("d_arvalid", {63'h0, d_arvalid}, 64'h1);
      d_arready = 1;
      @(negedge clk);
      d_arready = 0;
      chk("d_rready", {63'h0, d_rready}, 64'h1);
      d_rvalid = 1; d_rdata = 64'h8123_4567_89AB_CDEF;
      @(negedge clk);
      d_rvalid = 0;
      chk("d_resp_valid", {63'h0, d_resp_valid}, 64'h1);
      chk("d_rdata_dword", d_resp_rdata, m_load(64'h8123_4567_89AB_CDEF, 0, 8, 0));
      d_resp_ready = 1;
      @(negedge clk);
      d_resp_ready = 0;

      step++;
      d_req_valid = 1; d_req_addr = 32'h15; d_req_size = 2'd0; d_req_unsigned = 0;
      @(negedge clk);
      d_req_valid = 0; d_arready = 1;
      @(negedge clk);
      d_arready = 0; d_rvalid = 1; d_rdata = 64'h0000_9A00_0000_0000;
      @(negedge clk);
      d_rvalid = 0;
      chk("d_rdata_byte5", d_resp_rdata, m_load(64'h0000_9A00_0000_0000, 5, 1, 0));
      d_resp_ready = 1;
      @(negedge clk);
      d_resp_ready = 0;

      step++;
      d_req_valid = 1; d_req_addr = 32'h10; d_req_size = 2'd2;
      @(negedge clk);
      d_req_valid = 0; d_arready = 1;
      @(negedge clk);
      d_arready = 0;
      chk("d_in_rd_r", {62'h0, d_rready, d_arvalid}, 64'h2);
      d_rst = 1;
      @(negedge clk);
      chk("d_reset_mid", {61'h0, d_arvalid, d_rready, d_req_ready}, 64'h1);
      d_rst = 0;
      @(negedge clk);
      chk("d_after_reset", {60'h0, d_arvalid, d_rready, d_resp_valid, d_req_ready}, 64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
